// File: rtl/bp_wb_stream_tx.sv
// Writeback transmitter: walks the core's output buffers (address-major, group-minor) and
// streams the registered writeback words out as AXI-Stream beats through a credit-guarded FIFO.
module bp_wb_stream_tx #(
  parameter int unsigned BP_COLS    = 64,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         cfg_base_addr,
  input  logic [CNT_W-1:0]          cfg_num_words,
  input  logic [3:0]                cfg_num_grp,
  input  logic                      cfg_buf_sel,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                bp_out_buf_wb_en,
  output logic [BP_COLS*ADDR_W-1:0] bp_out_buf_wb_addr,
  output logic                      bp_out_buf_wb_sel,
  input  logic [127:0]              bp_out_wb_data,
  output logic [127:0]              m_axis_wb_tdata,
  output logic                      m_axis_wb_tvalid,
  input  logic                      m_axis_wb_tready,
  output logic                      m_axis_wb_tlast
);

  localparam int unsigned N_GRP  = BP_COLS / 8;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  num_words_q;
  logic [3:0]        num_grp_q;
  logic              buf_sel_q;
  logic [CNT_W-1:0]  w_cnt_q;
  logic [2:0]        g_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        wb_en_q;
  logic [RD_LAT-1:0] vld_q, last_q;

  logic [127:0]      mem_data [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] cnt_q;

  logic       start_ok, grp_last, word_last, credit, issue, final_issue;
  logic       push, push_last, pop, drain_ok;
  logic [3:0] grp_clamped;

  assign start_ok    = (state_q == StIdle) && start;
  assign grp_clamped = (cfg_num_grp == 4'd0 || cfg_num_grp > 4'(N_GRP)) ? 4'(N_GRP) : cfg_num_grp;
  assign grp_last    = ({1'b0, g_cnt_q} == (num_grp_q - 4'd1));
  assign word_last   = (w_cnt_q == (num_words_q - CNT_W'(1)));
  // Every in-flight read owns a FIFO slot, so backpressure can never drop a word.
  assign credit      = (int'(cnt_q) + $countones(vld_q)) < int'(FIFO_DEPTH);
  assign issue       = (state_q == StRun) && credit;
  assign final_issue = issue && grp_last && word_last;

  assign push      = vld_q[RD_LAT-1];
  assign push_last = last_q[RD_LAT-1];
  assign pop       = m_axis_wb_tvalid && m_axis_wb_tready;
  assign drain_ok  = (vld_q == '0) && ((cnt_q == '0) || (cnt_q == FCNT_W'(1) && pop));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = (cfg_num_words == '0) ? StDone : StRun;
      StRun:   if (final_issue) state_d = StDrain;
      StDrain: if (drain_ok) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_words_q <= '0;
      num_grp_q   <= '0;
      buf_sel_q   <= 1'b0;
      w_cnt_q     <= '0;
      g_cnt_q     <= '0;
      addr_q      <= '0;
      wb_en_q     <= '0;
      vld_q       <= '0;
      last_q      <= '0;
    end else begin
      if (start_ok) begin
        num_words_q <= cfg_num_words;
        num_grp_q   <= grp_clamped;
        buf_sel_q   <= cfg_buf_sel;
        w_cnt_q     <= '0;
        g_cnt_q     <= '0;
        if (cfg_num_words != '0) addr_q <= cfg_base_addr;
      end
      // addr_q always shows the pending issue; it stays on the last address after the job.
      if (issue) begin
        wb_en_q <= g_cnt_q;
        if (grp_last) begin
          g_cnt_q <= '0;
          if (!word_last) begin
            w_cnt_q <= w_cnt_q + CNT_W'(1);
            addr_q  <= addr_q + ADDR_W'(1);
          end
        end else begin
          g_cnt_q <= g_cnt_q + 3'd1;
        end
      end
      vld_q  <= {vld_q[RD_LAT-2:0], issue};
      last_q <= {last_q[RD_LAT-2:0], final_issue};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + FCNT_W'(1);
        2'b01:   cnt_q <= cnt_q - FCNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= bp_out_wb_data;
      mem_last[wr_ptr_q] <= push_last;
    end
  end

  // Storage is not reset; gating with tvalid keeps the stream outputs at 0 when empty.
  assign m_axis_wb_tvalid   = (cnt_q != '0);
  assign m_axis_wb_tdata    = m_axis_wb_tvalid ? mem_data[rd_ptr_q] : '0;
  assign m_axis_wb_tlast    = m_axis_wb_tvalid && mem_last[rd_ptr_q];
  assign bp_out_buf_wb_en   = wb_en_q;
  assign bp_out_buf_wb_addr = {BP_COLS{addr_q}};
  assign bp_out_buf_wb_sel  = busy && buf_sel_q;

endmodule

// File: tb/tb_bp_wb_stream_tx.sv
// Bench for bp_wb_stream_tx: a core read model feeds writeback words, and every stream beat is
// compared with a queue built from the nested word/group issue order.
module tb_bp_wb_stream_tx;

  localparam int BP_COLS = 64;
  localparam int ADDR_W  = 10;
  localparam int CNT_W   = 16;
  localparam int AW      = BP_COLS * ADDR_W;
  localparam int CW      = AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] cfg_base_addr = '0;
  logic [CNT_W-1:0]  cfg_num_words = '0;
  logic [3:0]        cfg_num_grp = '0;
  logic              cfg_buf_sel = 1'b0;
  logic              busy, done;
  logic [2:0]        bp_out_buf_wb_en;
  logic [AW-1:0]     bp_out_buf_wb_addr;
  logic              bp_out_buf_wb_sel;
  logic [127:0]      bp_out_wb_data;
  logic [127:0]      m_axis_wb_tdata;
  logic              m_axis_wb_tvalid;
  logic              m_axis_wb_tready = 1'b0;
  logic              m_axis_wb_tlast;

  always #5 clk = ~clk;

  bp_wb_stream_tx #(
    .BP_COLS(BP_COLS), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RD_LAT(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_num_words(cfg_num_words),
    .cfg_num_grp(cfg_num_grp), .cfg_buf_sel(cfg_buf_sel),
    .busy(busy), .done(done),
    .bp_out_buf_wb_en(bp_out_buf_wb_en), .bp_out_buf_wb_addr(bp_out_buf_wb_addr),
    .bp_out_buf_wb_sel(bp_out_buf_wb_sel), .bp_out_wb_data(bp_out_wb_data),
    .m_axis_wb_tdata(m_axis_wb_tdata), .m_axis_wb_tvalid(m_axis_wb_tvalid),
    .m_axis_wb_tready(m_axis_wb_tready), .m_axis_wb_tlast(m_axis_wb_tlast)
  );

  function automatic logic [127:0] model_word(input logic [2:0] g, input logic [ADDR_W-1:0] a,
                                              input logic s);
    logic [31:0] h;
    h = {17'h0, s, g, 1'b0, a} ^ 32'h5A5A_C3C3;
    h = h * 32'h9E37_79B1;
    return {h, ~h, {s, g, 18'h2_AAAA, a}, h ^ 32'hFFFF_0000};
  endfunction

  // Core model: buffer read on the address, group mux register on wb_en one cycle later.
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_sel = 1'b0;
  always @(posedge clk) begin : core_model
    int col;
    col = int'($urandom_range(BP_COLS - 1));
    rd_addr        <= bp_out_buf_wb_addr[col*ADDR_W +: ADDR_W];
    rd_sel         <= bp_out_buf_wb_sel;
    bp_out_wb_data <= model_word(bp_out_buf_wb_en, rd_addr, rd_sel);
  end

  typedef struct packed {logic [127:0] d; logic l;} beat_t;
  beat_t exp_q[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0, beats = 0, done_cnt = 0, done_cyc = -1, last_hs_cyc = -1, vrise_cyc = -1;
  int tr_mode = 0, stall_left = 0, phase = 0;
  logic prev_stall = 1'b0, prev_valid = 1'b0, prev_last = 1'b0;
  logic [127:0] prev_data = '0;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_tready();
    case (tr_mode)
      0: m_axis_wb_tready = 1'b1;
      1: begin
        if (stall_left > 0) begin
          m_axis_wb_tready = 1'b0;
          stall_left--;
        end else if ($urandom_range(7) == 0) begin
          stall_left = int'($urandom_range(10, 1)) - 1;
          m_axis_wb_tready = 1'b0;
        end else begin
          m_axis_wb_tready = (phase == 0 || phase == 3);
          phase = (phase + 1) % 4;
        end
      end
      default: m_axis_wb_tready = 1'b0;
    endcase
  endtask

  // One clock: new tready first (it does not feed DUT outputs), then observe the stream.
  task automatic step();
    beat_t b;
    @(negedge clk);
    cyc++;
    drive_tready();
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", CW'(m_axis_wb_tvalid), CW'(1));
        check("stall_tdata", CW'(m_axis_wb_tdata), CW'(prev_data));
        check("stall_tlast", CW'(m_axis_wb_tlast), CW'(prev_last));
      end
      if (m_axis_wb_tvalid && !prev_valid) vrise_cyc = cyc;
      if (m_axis_wb_tvalid && m_axis_wb_tready) begin
        if (exp_q.size() == 0) begin
          check($sformatf("beat%0d_unexpected", beats), CW'(m_axis_wb_tvalid), '0);
        end else begin
          b = exp_q.pop_front();
          check($sformatf("beat%0d_data", beats), CW'(m_axis_wb_tdata), CW'(b.d));
          check($sformatf("beat%0d_last", beats), CW'(m_axis_wb_tlast), CW'(b.l));
        end
        beats++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) check("fifo_over_depth", CW'(dut.cnt_q > 3'd4), '0);
      prev_stall = m_axis_wb_tvalid && !m_axis_wb_tready;
      prev_valid = m_axis_wb_tvalid;
      prev_data  = m_axis_wb_tdata;
      prev_last  = m_axis_wb_tlast;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, CW'(busy), '0);
    check({tag, "_done"}, CW'(done), '0);
    check({tag, "_tvalid"}, CW'(m_axis_wb_tvalid), '0);
    check({tag, "_tlast"}, CW'(m_axis_wb_tlast), '0);
    check({tag, "_tdata"}, CW'(m_axis_wb_tdata), '0);
    check({tag, "_wb_en"}, CW'(bp_out_buf_wb_en), '0);
    check({tag, "_wb_addr"}, CW'(bp_out_buf_wb_addr), '0);
    check({tag, "_wb_sel"}, CW'(bp_out_buf_wb_sel), '0);
  endtask

  task automatic load_expected(input logic [ADDR_W-1:0] base, input int words, input int ng,
                               input logic sel);
    beat_t b;
    for (int w = 0; w < words; w++) begin
      for (int g = 0; g < ng; g++) begin
        b.d = model_word(3'(g), ADDR_W'(int'(base) + w), sel);
        b.l = (w == words - 1) && (g == ng - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] base, input int words, input logic [3:0] grp,
                             input logic sel);
    start = 1'b1;
    cfg_base_addr = base;
    cfg_num_words = CNT_W'(words);
    cfg_num_grp   = grp;
    cfg_buf_sel   = sel;
    step();
    start = 1'b0;
    cfg_base_addr = ADDR_W'($urandom);
    cfg_num_words = CNT_W'($urandom_range(1, 3));
    cfg_num_grp   = 4'($urandom);
    cfg_buf_sel   = ~sel;
  endtask

  task automatic run_job(input logic [ADDR_W-1:0] base, input int words, input logic [3:0] grp,
                         input logic sel, input bit mid_start, input bit timing);
    int ng, total, s_cyc, d0, b0, n;
    ng    = (grp == 4'd0 || grp > 4'd8) ? 8 : int'(grp);
    total = words * ng;
    load_expected(base, words, ng, sel);
    b0 = beats;
    d0 = done_cnt;
    s_cyc = cyc;
    pulse_start(base, words, grp, sel);
    check("busy_after_start", CW'(busy), CW'(1));
    check("sel_latched", CW'(bp_out_buf_wb_sel), CW'(sel));
    if (mid_start) begin
      repeat (5) step();
      start = 1'b1;
      step();
      start = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      step();
      n++;
    end
    repeat (2) step();
    check("done_pulses", CW'(done_cnt - d0), CW'(1));
    check("busy_after_done", CW'(busy), '0);
    check("beat_count", CW'(beats - b0), CW'(total));
    check("beats_left", CW'(exp_q.size()), '0);
    if (total > 0) begin
      check("done_lag", CW'(done_cyc - last_hs_cyc), CW'(1));
      check("wb_addr_final", CW'(bp_out_buf_wb_addr),
            CW'({BP_COLS{ADDR_W'(int'(base) + words - 1)}}));
      check("wb_en_final", CW'(bp_out_buf_wb_en), CW'(ng - 1));
      if (timing) begin
        check("first_valid_latency", CW'(vrise_cyc - s_cyc), CW'(4));
        check("stream_span", CW'(last_hs_cyc - vrise_cyc), CW'(total - 1));
      end
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [ADDR_W-1:0] base_c, exp_a;
    logic              sel;
    int                d0, b0, n;

    repeat (3) step();
    check_idle("reset");
    rst_n = 1'b1;
    step();
    check_idle("post_reset");

    // Address wrap across 0x3FF at full rate.
    sel = 1'($urandom);
    tr_mode = 0;
    run_job(10'h3FE, 4, 4'd8, sel, 1'b0, 1'b1);

    // Same job under 1-0-0-1 and random stalls.
    tr_mode = 1;
    run_job(10'h3FE, 4, 4'd8, ~sel, 1'b0, 1'b0);

    // A second start while busy must be ignored.
    base_c = ADDR_W'($urandom);
    run_job(base_c, 4, 4'd8, 1'($urandom), 1'b1, 1'b0);

    // Zero-word job: DONE only, no beats, read port untouched.
    exp_a = base_c + ADDR_W'(3);
    d0 = done_cnt;
    b0 = beats;
    tr_mode = 0;
    pulse_start(ADDR_W'($urandom), 0, 4'd3, 1'b1);
    check("nw0_busy", CW'(busy), CW'(1));
    check("nw0_done", CW'(done), CW'(1));
    check("nw0_tvalid", CW'(m_axis_wb_tvalid), '0);
    step();
    check("nw0_busy_after", CW'(busy), '0);
    check("nw0_done_after", CW'(done), '0);
    repeat (4) step();
    check("nw0_done_pulses", CW'(done_cnt - d0), CW'(1));
    check("nw0_beats", CW'(beats - b0), '0);
    check("nw0_wb_addr", CW'(bp_out_buf_wb_addr), CW'({BP_COLS{exp_a}}));
    check("nw0_wb_en", CW'(bp_out_buf_wb_en), CW'(7));

    // Reset in the middle of a job, then a short job must run cleanly.
    tr_mode = 1;
    load_expected(ADDR_W'($urandom), 4, 8, 1'b0);
    d0 = done_cnt;
    b0 = beats;
    pulse_start(exp_q[0].d[41:32], 4, 4'd8, 1'b0);
    n = 0;
    while (beats - b0 < 10 && n < 2000) begin
      step();
      n++;
    end
    check("reached_beat10", CW'(beats - b0 >= 10), CW'(1));
    tr_mode = 2;
    rst_n = 1'b0;
    step();
    check_idle("mid_reset");
    rst_n = 1'b1;
    repeat (5) step();
    check("no_done_after_reset", CW'(done_cnt - d0), '0);
    check_idle("after_mid_reset");
    exp_q.delete();
    tr_mode = 0;
    run_job(ADDR_W'($urandom), 3, 4'd2, 1'($urandom), 1'b0, 1'b1);

    // Group count clamping.
    run_job(ADDR_W'($urandom), 1, 4'd0, 1'($urandom), 1'b0, 1'b1);
    tr_mode = 1;
    run_job(ADDR_W'($urandom), int'($urandom_range(5, 1)), 4'($urandom_range(15, 9)),
            1'($urandom), 1'b0, 1'b0);
    run_job(ADDR_W'($urandom), int'($urandom_range(6, 1)), 4'($urandom_range(8, 1)),
            1'($urandom), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
